// File: rtl/yd_pkg.sv
// Shared definitions for the data-bus UART: register offsets, TX state
// encoding and STATUS bit positions.
package yd_pkg;

  // Register offsets inside the four-word window
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;

  // Transmitter state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // STATUS register bit positions
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

endpackage

// File: rtl/yd_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is accepted
// only when a pop happens in the same cycle. DEPTH must be a power of two.
module yd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, not reset: contents are only meaningful behind count
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/yd_dbus_uart.sv
// Memory-mapped 8N1 UART transmitter on the core data bus: register decode,
// STATUS/DIV registers, TX FIFO, baud counter and the serialising FSM.
module yd_dbus_uart
  import yd_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter logic [15:0] CLK_DIV    = 16'd434,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_din,
  input  logic        d_we,
  output logic [15:0] d_dout,
  output logic        sel,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   offset;
  logic [1:0]    reg_sel;
  logic          wr_txdata;
  logic          wr_status;
  logic          wr_div;

  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic          pop;

  logic          ovf;
  logic [15:0]   div_reg;
  logic [15:0]   div_eff;

  tx_state_t     state;
  tx_state_t     state_n;
  logic [15:0]   bit_cnt;
  logic [15:0]   cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    idx_n;
  logic [7:0]    shifter;
  logic [7:0]    shift_n;
  logic          tx_n;
  logic          boundary;

  assign offset    = d_addr - BASE_ADDR;
  assign sel       = (offset[15:2] == 14'd0);
  assign reg_sel   = offset[1:0];
  assign wr_txdata = sel && d_we && (reg_sel == UART_TXDATA);
  assign wr_status = sel && d_we && (reg_sel == UART_STATUS);
  assign wr_div    = sel && d_we && (reg_sel == UART_DIV);

  // A programmed divisor of zero runs at one cycle per bit
  assign div_eff  = (div_reg == 16'd0) ? 16'd1 : div_reg;
  assign boundary = (bit_cnt == 16'd1);
  assign pop      = (state == IDLE) && !fifo_empty;

  yd_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (pop),
    .din   (d_din[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Combinational read mux; deselected or reserved addresses read zero
  always_comb begin
    d_dout = 16'h0000;
    if (sel) begin
      case (reg_sel)
        UART_STATUS: begin
          d_dout[STAT_EMPTY] = fifo_empty;
          d_dout[STAT_FULL]  = fifo_full;
          d_dout[STAT_BUSY]  = (state != IDLE);
          d_dout[STAT_OVF]   = ovf;
        end
        UART_DIV: d_dout = div_reg;
        default:  d_dout = 16'h0000;
      endcase
    end
  end

  // Sticky overflow (dropped push) and the divisor register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf     <= 1'b0;
      div_reg <= CLK_DIV;
    end else begin
      if (wr_txdata && fifo_full && !pop) ovf <= 1'b1;
      else if (wr_status)                 ovf <= 1'b0;
      if (wr_div) div_reg <= d_din;
    end
  end

  // Next-state logic: the bit counter reloads from DIV at every boundary
  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    idx_n   = bit_idx;
    shift_n = shifter;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_n = START;
          cnt_n   = div_eff;
          idx_n   = 3'd0;
          shift_n = fifo_dout;
        end
      end
      START: begin
        if (boundary) begin
          state_n = DATA;
          cnt_n   = div_eff;
        end else begin
          cnt_n = bit_cnt - 16'd1;
        end
      end
      DATA: begin
        if (boundary) begin
          cnt_n   = div_eff;
          shift_n = {1'b0, shifter[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 idx_n   = bit_idx + 3'd1;
        end else begin
          cnt_n = bit_cnt - 16'd1;
        end
      end
      STOP: begin
        if (boundary) state_n = IDLE;
        else          cnt_n   = bit_cnt - 16'd1;
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // FSM control registers; reset drives the line idle-high immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      tx      <= 1'b1;
      irq     <= 1'b1;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      bit_idx <= idx_n;
      tx      <= tx_n;
      irq     <= (fifo_cnt == '0) && (state == IDLE);
    end
  end

  // Shift register holds frame data only, so it carries no reset
  always_ff @(posedge clk) begin
    shifter <= shift_n;
  end

endmodule

// File: tb/tb_yd_dbus_uart.sv
// Self-checking bench for yd_dbus_uart: reset/decode table, directed frame
// sequences, and randomized traffic compared against a frame-level model.
module tb_yd_dbus_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_addr;
  logic [15:0] d_din;
  logic        d_we;
  logic [15:0] d_dout;
  logic        sel;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  yd_dbus_uart #(
    .BASE_ADDR  (16'hFF00),
    .CLK_DIV    (16'd434),
    .FIFO_DEPTH (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .d_addr (d_addr),
    .d_din  (d_din),
    .d_we   (d_we),
    .d_dout (d_dout),
    .sel    (sel),
    .tx     (tx),
    .irq    (irq)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // The model knows only: bytes queue up to 4 deep, a frame takes 10*DIV
  // cycles, and the next frame may start one cycle after the previous ends.
  logic        s_we, s_en;
  logic [15:0] s_addr, s_din;
  bit          model_en = 1'b0;
  int          model_div = 4;
  byte unsigned mq[$];
  int          n = 0;
  bit          have_frame;
  int          last_pop;
  logic [7:0]  cur_byte;
  bit          m_ovf, m_busy, flag_prev, exp_irq, m_pop, m_full_b;

  always @(posedge clk) begin
    s_we   <= d_we;
    s_addr <= d_addr;
    s_din  <= d_din;
    s_en   <= model_en;
  end

  function automatic logic exp_tx();
    int k;
    if (have_frame && n < last_pop + 10 * model_div) begin
      k = n - last_pop;
      if (k < model_div) return 1'b0;
      if (k < 9 * model_div) return cur_byte[(k - model_div) / model_div];
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    n++;
    if (!s_en) begin
      mq.delete();
      have_frame = 1'b0;
      m_ovf      = 1'b0;
      flag_prev  = 1'b1;
      exp_irq    = 1'b1;
    end else begin
      m_pop    = (mq.size() > 0) && (!have_frame || n >= last_pop + 10 * model_div + 1);
      m_full_b = (mq.size() == 4);
      exp_irq  = flag_prev;
      if (m_pop) begin
        cur_byte   = mq.pop_front();
        last_pop   = n;
        have_frame = 1'b1;
      end
      if (s_we && s_addr == 16'hFF00) begin
        if (!m_full_b || m_pop) mq.push_back(s_din[7:0]);
        else                    m_ovf = 1'b1;
      end
      if (s_we && s_addr == 16'hFF01) m_ovf = 1'b0;
      m_busy    = have_frame && (n < last_pop + 10 * model_div);
      flag_prev = (mq.size() == 0) && !m_busy;
      check("model_tx", tx, exp_tx());
      check("model_irq", irq, exp_irq);
      if (d_addr == 16'hFF01)
        check("model_status", d_dout,
              {12'h0, m_ovf, m_busy, mq.size() == 4, mq.size() == 0});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    d_addr = a;
    d_din  = d;
    d_we   = 1'b1;
    @(posedge clk);
    #1;
    d_we   = 1'b0;
    d_addr = 16'hFF01;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      #1;
      d_addr = 16'hFF01;
      #1;
      if (d_dout[2:0] == 3'b001) done = 1'b1;
    end
    check("drain_done", done, 1'b1);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        exp_sel;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t        tv[7];
  logic [39:0] wave40, exp40;
  logic [59:0] wave60, exp60;
  logic [9:0]  pat;
  int          busy_cnt, tx_low, idx, v;
  int          durs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; d_we = 1'b0; d_addr = 16'h0000; d_din = 16'h0000;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_irq", irq, 1'b1);
    d_addr = 16'hFF01; #1;
    check("rst_status", d_dout, 16'h0001);
    d_addr = 16'hFF02; #1;
    check("rst_div", d_dout, 16'd434);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Decode table after reset
    tv[0] = '{16'hFEFF, 1'b0, 16'h0000};
    tv[1] = '{16'hFF00, 1'b1, 16'h0000};
    tv[2] = '{16'hFF01, 1'b1, 16'h0001};
    tv[3] = '{16'hFF02, 1'b1, 16'd434};
    tv[4] = '{16'hFF03, 1'b1, 16'h0000};
    tv[5] = '{16'hFF04, 1'b0, 16'h0000};
    tv[6] = '{16'h0000, 1'b0, 16'h0000};
    for (int i = 0; i < 7; i++) begin
      d_addr = tv[i].addr;
      #1;
      check($sformatf("tbl_sel_%0d", i), sel, tv[i].exp_sel);
      check($sformatf("tbl_dout_%0d", i), d_dout, tv[i].exp_dout);
    end

    // Reserved register ignores writes
    @(posedge clk); #1;
    wr(16'hFF03, 16'hBEEF);
    d_addr = 16'hFF02; #1;
    check("rsv_div", d_dout, 16'd434);
    d_addr = 16'hFF01; #1;
    check("rsv_status", d_dout, 16'h0001);

    wr(16'hFF02, 16'd4);
    d_addr = 16'hFF02; #1;
    check("div4", d_dout, 16'd4);

    // Single byte 0xA5
    model_div = 4;
    model_en  = 1'b1;
    wr(16'hFF00, 16'h00A5);
    busy_cnt = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (d_dout[2]) busy_cnt++;
      if (c <= 40) wave40[c-1] = tx;
    end
    pat = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < 40; j++) exp40[j] = pat[j/4];
    check("a5_wave", wave40, exp40);
    check("a5_busy_cycles", busy_cnt, 40);
    check("a5_irq_after", irq, 1'b1);

    // Overflow: six back-to-back writes
    for (int i = 0; i < 6; i++) wr(16'hFF00, 16'h0010 + 16'(i));
    #1;
    check("ovf_status", d_dout, 16'h000E);
    wr(16'hFF01, 16'h0000);
    #1;
    check("ovf_cleared", d_dout, 16'h0006);
    wait_idle();

    // Push coinciding with the idle pop while full
    wr(16'hFF00, 16'h0031);
    for (int i = 2; i <= 5; i++) wr(16'hFF00, 16'h0030 + 16'(i));
    repeat (37) @(posedge clk);
    #1;
    wr(16'hFF00, 16'h0036);
    #1;
    check("pushpop_full_status", d_dout, 16'h0006);
    wait_idle();
    model_en = 1'b0;
    @(posedge clk); #1;

    // Mid-frame divisor change during data bit 3
    wr(16'hFF00, 16'h0055);
    for (int c = 1; c <= 60; c++) begin
      if (c == 18) begin
        d_addr = 16'hFF02; d_din = 16'd8; d_we = 1'b1;
      end
      @(posedge clk); #1;
      d_we = 1'b0; d_addr = 16'hFF01;
      wave60[c-1] = tx;
    end
    durs = '{4, 4, 4, 4, 4, 8, 8, 8, 8, 8};
    idx = 0;
    for (int s = 0; s < 10; s++)
      for (int d = 0; d < durs[s]; d++) begin
        exp60[idx] = s[0];
        idx++;
      end
    check("divchg_wave", wave60, exp60);
    check("divchg_bit3_last", wave60[19], 1'b0);
    check("divchg_bit4_first", wave60[20], 1'b1);
    check("divchg_bit4_last", wave60[27], 1'b1);
    check("divchg_bit5_first", wave60[28], 1'b0);
    wait_idle();
    wr(16'hFF02, 16'd4);

    // Asynchronous reset mid-frame with three bytes queued
    for (int i = 0; i < 4; i++) wr(16'hFF00, 16'h0041 + 16'(i));
    check("prerst_tx_low", tx, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_tx_high", tx, 1'b1);
    check("async_irq", irq, 1'b1);
    d_addr = 16'hFF01; #1;
    check("async_status", d_dout, 16'h0001);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tx_low = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) tx_low++;
    end
    check("postrst_no_frames", tx_low, 0);
    check("postrst_status", d_dout, 16'h0001);
    d_addr = 16'h1234; #1;
    check("outside_sel", sel, 1'b0);
    check("outside_dout", d_dout, 16'h0000);
    d_addr = 16'hFF02; #1;
    check("postrst_div", d_dout, 16'd434);

    // Randomized traffic against the model
    for (int r = 0; r < 2; r++) begin
      v = (r == 0) ? 0 : int'($urandom_range(1, 3));
      @(posedge clk); #1;
      wr(16'hFF02, 16'(v));
      d_addr = 16'hFF02; #1;
      check("rand_div_rb", d_dout, 16'(v));
      model_div = (v == 0) ? 1 : v;
      model_en  = 1'b1;
      for (int i = 0; i < 300; i++) begin
        int k;
        k = int'($urandom_range(0, 9));
        if (k < 5)       wr(16'hFF00, 16'($urandom_range(0, 255)));
        else if (k == 5) wr(16'hFF01, 16'h0000);
        else begin
          d_addr = 16'hFF01;
          @(posedge clk); #1;
        end
      end
      wait_idle();
      wr(16'hFF01, 16'h0000);
      model_en = 1'b0;
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yd_dbus_uart.md
# yd_dbus_uart

Memory-mapped UART transmitter that sits directly downstream of the core's data bus (`d_addr`/`d_din`/`d_we`/`d_dout`). It decodes a small register window, buffers written bytes in a 4-entry FIFO, and serialises them as 8N1 frames on `tx`. Read data is returned combinationally in the same cycle, which matches the core's single-cycle `LD` timing. The top level ORs `d_dout` with the data RAM output, qualified by `sel`.

## Interface
Parameters:
- `BASE_ADDR`, 16'hFF00: word address of register 0; the window is `BASE_ADDR`..`BASE_ADDR+3`.
- `CLK_DIV`, 16'd434: reset value of the baud divisor (clock cycles per bit).
- `FIFO_DEPTH`, 4: TX FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `d_addr`  in  16  data-bus address.
- `d_din`  in  16  data-bus write data.
- `d_we`  in  1  write enable, sampled on the `clk` rising edge.
- `d_dout`  out  16  read data, combinational from `d_addr`; 16'h0 when not selected.
- `sel`  out  1  high when `d_addr` is inside the window.
- `tx`  out  1  serial output, idle high.
- `irq`  out  1  registered; high while the FIFO is empty and the shifter is idle.

## Operation
Register map (offset from `BASE_ADDR`):
- **+0 TXDATA**
  - Write pushes `d_din[7:0]`.
  - Read returns 0.
- **+1 STATUS**
  - Read returns `{12'h0, ovf, busy, full, empty}`.
  - Any write clears `ovf`.
- **+2 DIV**
  - Read/write, 16 bits.
  - A value of 0 behaves as 1.
- **+3** is reserved: reads 0, writes are ignored.

FIFO:
- Write to TXDATA while full:
  - the byte is dropped and `ovf` sets (sticky);
  - exception: if a pop occurs in the same cycle, the push is accepted and `ovf` is not set.
- Simultaneous push and pop while not full: count is unchanged and data ordering is preserved.
- Read and write pointers wrap modulo `FIFO_DEPTH`.

TX state machine:
- **IDLE**: `tx`=1. If the FIFO is non-empty, pop the head into an 8-bit shifter, load the bit counter with DIV, and go to START.
- **START**: `tx`=0 for DIV cycles, then go to DATA.
- **DATA**: `tx`=shifter[0], 8 bits LSB-first, DIV cycles each, then go to STOP.
- **STOP**: `tx`=1 for DIV cycles, then go to IDLE.

Divisor and status behaviour:
- The bit counter reloads from the DIV register at every bit boundary. A DIV write mid-frame affects the next bit only.
- `busy` = state != IDLE.
- `irq` = `empty` AND state==IDLE, registered one cycle.

Reset values:
- `tx`=1, state IDLE, FIFO empty, `ovf`=0, DIV=`CLK_DIV`, `irq`=1.
- `d_dout` and `sel` are combinational and follow `d_addr`.
- Reset mid-frame forces `tx` high immediately (asynchronous) and discards all queued bytes.

## Timing
- Write accepted at edge E0; FIFO count updates at E0.
- IDLE pops at E1. `tx` falls after E1 and the start bit begins.
- Frame length is 10×DIV cycles. Back-to-back frames are separated by exactly one IDLE cycle (10×DIV+1 cycle period).
- STATUS reads reflect register state as of the last edge, with zero-cycle read latency.
- `empty` clears the cycle after the write edge and sets the cycle after the pop of the last entry.

## Structure
- Shared package `yd_pkg`:
  - register offsets `UART_TXDATA`/`UART_STATUS`/`UART_DIV`;
  - TX state encoding (2-bit enum IDLE/START/DATA/STOP);
  - STATUS bit positions.
- One sub-module: `yd_fifo` (synchronous FIFO, parameterised width/depth, push/pop/full/empty/count). It is reusable for a future RX path.
- The top module holds decode, registers, the baud counter and the FSM.

## Test plan
- **Reset behaviour:** reset asserted → `tx`=1, STATUS read at `BASE_ADDR+1` = 16'h0001, DIV read = 434, `irq`=1.
- **Single byte:** DIV=4, write 8'hA5 to TXDATA → `tx` low at cycles 1–4 after the write edge, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles. `busy` is high for 40 cycles.
- **Overflow:** DIV=4, 6 writes on consecutive cycles → the first byte pops at E1, so 5 bytes are accepted and 1 dropped. STATUS shows `ovf`=1 and `full`=1. A write to STATUS clears `ovf`. Exactly 5 frames emerge, each 41 cycles apart.
- **Simultaneous push/pop at full:** FIFO full, push in the same cycle as the IDLE pop → accepted, `ovf`=0, all bytes transmitted in order.
- **Mid-frame DIV change:** DIV=4, then write DIV=8 during bit 3 → bit 3 still lasts 4 cycles, subsequent bits last 8 cycles.
- **Async reset mid-frame with 3 bytes queued:** → `tx`=1 immediately without waiting for a clock, FIFO empty, no further frames, and reads outside the window return `d_dout`=0 with `sel`=0.
